axi4_lite_slave_regs: RTL and testbench

- AXI4-Lite slave register bank that sits directly downstream of the team's AXI4-Lite master and terminates its AW/W/B/AR/R channels.
- Holds NUM_REGS 32-bit registers, decodes word addresses and returns OKAY/SLVERR responses.
- Exposes register contents and a write strobe to user logic.
- Write and read paths are independent FSMs and may run concurrently.

---
 rtl/axi4_lite_pkg.sv | 24 ++
 rtl/axi4_lite_reg_bank.sv | 75 +++++++
 rtl/axi4_lite_slave_regs.sv | 178 +++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared constants and state encodings for the AXI4-Lite register slave.
package axi4_lite_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WS_COLLECT = 2'd0,
    WS_COMMIT  = 2'd1,
    WS_RESP    = 2'd2
  } wr_state_e;

  typedef enum logic {
    RS_ADDR = 1'b0,
    RS_DATA = 1'b1
  } rd_state_e;

  function automatic logic [1:0] resp_for(input logic ok);
    return ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Register storage with address decode, one write port and one combinational read port.
// AXIL_SLV_RO_ID_EN turns register 0 into a read-only ID register.
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'hA11E_0001
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en_i,
  input  logic [31:0]                  wr_addr_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  output logic                         wr_ok_o,
  output logic [$clog2(NUM_REGS)-1:0]  wr_idx_o,
  input  logic [31:0]                  rd_addr_i,
  output logic                         rd_ok_o,
  output logic [DATA_W-1:0]            rd_data_o,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

  localparam int          IDX_W = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN  = 32'(NUM_REGS * 4);

`ifdef AXIL_SLV_RO_ID_EN
  localparam bit RO_ID = 1'b1;
`else
  localparam bit RO_ID = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // A 33-bit difference gives the "addr >= BASE_ADDR" test as the absence of a borrow.
  logic [32:0]      wr_diff;
  logic [32:0]      rd_diff;
  logic             wr_hit;
  logic             rd_hit;
  logic [IDX_W-1:0] rd_idx;

  assign wr_diff  = {1'b0, wr_addr_i} - {1'b0, BASE_ADDR};
  assign rd_diff  = {1'b0, rd_addr_i} - {1'b0, BASE_ADDR};
  assign wr_hit   = !wr_diff[32] && (wr_diff[31:0] < SPAN);
  assign rd_hit   = !rd_diff[32] && (rd_diff[31:0] < SPAN);
  assign wr_idx_o = wr_diff[2 +: IDX_W];
  assign rd_idx   = rd_diff[2 +: IDX_W];

  assign wr_ok_o   = wr_hit && !(RO_ID && (wr_idx_o == '0));
  assign rd_ok_o   = rd_hit;
  assign rd_data_o = !rd_hit                     ? '0       :
                     (RO_ID && (rd_idx == '0))  ? ID_VALUE :
                                                   regs_q[rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i && wr_ok_o) begin
      regs_q[wr_idx_o] <= wr_data_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_out
      if (RO_ID && (gi == 0)) begin : g_id
        assign regs_o[DATA_W*gi +: DATA_W] = ID_VALUE;
      end else begin : g_rw
        assign regs_o[DATA_W*gi +: DATA_W] = regs_q[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave terminating AW/W/B/AR/R onto a bank of NUM_REGS 32-bit registers.
// Optional read-only ID register 0 is selected with AXIL_SLV_RO_ID_EN (see axi4_lite_reg_bank).
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'hA11E_0001
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         awvalid,
  input  logic [31:0]                  awaddr,
  output logic                         awready,
  input  logic                         wvalid,
  input  logic [31:0]                  wdata,
  output logic                         wready,
  output logic                         bvalid,
  output logic [1:0]                   bresp,
  input  logic                         bready,
  input  logic                         arvalid,
  input  logic [31:0]                  araddr,
  output logic                         arready,
  output logic                         rvalid,
  output logic [31:0]                  rdata,
  output logic [1:0]                   rresp,
  input  logic                         rready,
  output logic [NUM_REGS*32-1:0]       regs_out,
  output logic                         wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0]  wr_index
);

  localparam int IDX_W = $clog2(NUM_REGS);

  wr_state_e         wstate_q;
  logic              aw_got_q;
  logic              w_got_q;
  logic [31:0]       awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              wr_strobe_q;
  logic [IDX_W-1:0]  wr_index_q;

  rd_state_e         rstate_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              wr_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_data;

  assign aw_hs = awvalid && awready_q;
  assign w_hs  = wvalid && wready_q;
  assign ar_hs = arvalid && arready_q;

  axi4_lite_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .ID_VALUE  (ID_VALUE)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wstate_q == WS_COMMIT),
    .wr_addr_i (awaddr_q),
    .wr_data_i (wdata_q),
    .wr_ok_o   (wr_ok),
    .wr_idx_o  (wr_idx),
    .rd_addr_i (araddr),
    .rd_ok_o   (rd_ok),
    .rd_data_o (rd_data),
    .regs_o    (regs_out)
  );

  // Write path: AW and W each fill a one-deep slot; the slots may refill while B is pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wstate_q    <= WS_COLLECT;
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      awready_q   <= !awready_q && awvalid && !aw_got_q;
      wready_q    <= !wready_q && wvalid && !w_got_q;
      if (aw_hs) begin
        aw_got_q <= 1'b1;
        awaddr_q <= awaddr;
      end
      if (w_hs) begin
        w_got_q <= 1'b1;
        wdata_q <= wdata;
      end
      case (wstate_q)
        WS_COLLECT: begin
          if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
            wstate_q <= WS_COMMIT;
          end
        end
        WS_COMMIT: begin
          aw_got_q    <= 1'b0;
          w_got_q     <= 1'b0;
          bvalid_q    <= 1'b1;
          bresp_q     <= resp_for(wr_ok);
          wr_strobe_q <= wr_ok;
          if (wr_ok) begin
            wr_index_q <= wr_idx;
          end
          wstate_q    <= WS_RESP;
        end
        WS_RESP: begin
          if (bready) begin
            bvalid_q <= 1'b0;
            wstate_q <= WS_COLLECT;
          end
        end
        default: wstate_q <= WS_COLLECT;
      endcase
    end
  end

  // Read path: rd_data is sampled before any same-edge commit, so a colliding read sees the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstate_q  <= RS_ADDR;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= !arready_q && arvalid && (rstate_q == RS_ADDR);
      case (rstate_q)
        RS_ADDR: begin
          if (ar_hs) begin
            rdata_q  <= rd_data;
            rresp_q  <= resp_for(rd_ok);
            rvalid_q <= 1'b1;
            rstate_q <= RS_DATA;
          end
        end
        RS_DATA: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            rstate_q <= RS_ADDR;
          end
        end
        default: rstate_q <= RS_ADDR;
      endcase
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign arready   = arready_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: vector table plus hand-written corner sequences.
module tb_axi4_lite_slave_regs;
  import axi4_lite_pkg::*;

  localparam int          NREGS = 8;
  localparam logic [31:0] IDV   = 32'hA11E_0001;
`ifdef AXIL_SLV_RO_ID_EN
  localparam bit RO = 1'b1;
`else
  localparam bit RO = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]          awaddr, wdata, araddr;
  logic                 awready, wready, bvalid, arready, rvalid, wr_strobe;
  logic [1:0]           bresp, rresp;
  logic [31:0]          rdata;
  logic [NREGS*32-1:0]  regs_out;
  logic [2:0]           wr_index;

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(
    .NUM_REGS (NREGS),
    .BASE_ADDR(32'h0000_0000),
    .ID_VALUE (IDV)
  ) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_index(wr_index)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  int          sq [$];
  logic [31:0] mdl [NREGS];
  logic [33:0] r_exp;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          ok;
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vec [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    logic [NREGS*32-1:0] e;
    for (int i = 0; i < NREGS; i++) e[32*i +: 32] = (RO && i == 0) ? IDV : mdl[i];
    checks++;
    if (regs_out !== e) begin
      errors++;
      $display("FAIL %s: regs_out got %h expected %h", name, regs_out, e);
    end
  endtask

  // Scoreboard side: pop expectations when the DUT presents a response or a strobe.
  always @(negedge clk) begin
    if (reset) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_b: got bresp %b expected no response", bresp);
        end else begin
          chk("bresp", 32'(bresp), 32'(bq.pop_front()));
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_r: got rdata %h expected no response", rdata);
        end else begin
          r_exp = rq.pop_front();
          chk("rdata", rdata, r_exp[31:0]);
          chk("rresp", 32'(rresp), 32'(r_exp[33:32]));
        end
      end
      if (wr_strobe) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got wr_index %0d expected no strobe", wr_index);
        end else begin
          chk("wr_index", 32'(wr_index), 32'(sq.pop_front()));
        end
      end
    end
  end

  // Raises each valid at its cycle offset (-1 = unused) and drops it after its handshake.
  task automatic run_ch(input int aw_at, input int w_at, input int ar_at);
    bit aw_d, w_d, ar_d;
    int n;
    aw_d = (aw_at < 0); w_d = (w_at < 0); ar_d = (ar_at < 0);
    n = 0;
    while (!(aw_d && w_d && ar_d) && n < 40) begin
      if (!aw_d && n == aw_at) awvalid = 1'b1;
      if (!w_d && n == w_at)   wvalid  = 1'b1;
      if (!ar_d && n == ar_at) arvalid = 1'b1;
      @(negedge clk);
      if (awvalid && awready) aw_d = 1'b1;
      if (wvalid && wready)   w_d  = 1'b1;
      if (arvalid && arready) ar_d = 1'b1;
      @(posedge clk); #1;
      if (aw_d) awvalid = 1'b0;
      if (w_d)  wvalid  = 1'b0;
      if (ar_d) arvalid = 1'b0;
      n++;
    end
    if (!(aw_d && w_d && ar_d)) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: got aw=%0d w=%0d ar=%0d expected all 1", aw_d, w_d, ar_d);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("response_pending", 32'(bq.size() + rq.size()), 32'd0);
    bq.delete(); rq.delete();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit ok,
                          input int idx, input int aw_at, input int w_at);
    bq.push_back(ok ? RESP_OKAY : RESP_SLVERR);
    if (ok) begin
      sq.push_back(idx);
      mdl[idx] = data;
    end
    awaddr = addr; wdata = data;
    run_ch(aw_at, w_at, -1);
    @(negedge clk); chk("b_early", 32'(bvalid), 32'd0);
    @(negedge clk); chk("b_latency", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    wait_drain();
    chk("strobe_missing", 32'(sq.size()), 32'd0);
    sq.delete();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    rq.push_back({exp_resp, exp_data});
    araddr = addr;
    run_ch(-1, -1, 0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec[0] = '{32'h0000_0004, 32'hDEAD_BEEF, 1'b1, 1, 32'hDEAD_BEEF, RESP_OKAY};
    vec[1] = '{32'h0000_001C, 32'h7777_0007, 1'b1, 7, 32'h7777_0007, RESP_OKAY};
    vec[2] = '{32'h0000_0020, 32'h1111_2222, 1'b0, 0, 32'h0000_0000, RESP_SLVERR};
    vec[3] = '{32'h0000_000E, 32'h0000_00AA, 1'b1, 3, 32'h0000_00AA, RESP_OKAY};
    vec[4] = '{32'hFFFF_FFFC, 32'h0000_5A5A, 1'b0, 0, 32'h0000_0000, RESP_SLVERR};
    vec[5] = '{32'h0000_0000, 32'hCAFE_F00D, !RO, 0, RO ? IDV : 32'hCAFE_F00D,
               RO ? RESP_SLVERR : RESP_OKAY};
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;

    reset = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; wdata = 0; araddr = 0;
    #12;
    chk("rst_bvalid",  32'(bvalid), 32'd0);
    chk("rst_rvalid",  32'(rvalid), 32'd0);
    chk("rst_readies", 32'({awready, wready, arready}), 32'd0);
    chk("rst_strobe",  32'(wr_strobe), 32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    chk_regs("rst_regs");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_write(vec[i].addr, vec[i].data, vec[i].ok, vec[i].idx, 0, 0);
      chk_regs("regs_after_write");
      do_read(vec[i].addr, vec[i].rdata, vec[i].rresp);
    end

    // W leads AW by three cycles: single commit once AW arrives.
    do_write(32'h8, 32'h1234, 1'b1, 2, 3, 0);
    repeat (3) @(negedge clk);
    chk("single_bvalid", 32'(bvalid), 32'd0);
    chk_regs("regs_w_first");
    @(posedge clk); #1;

    // B backpressure with a second write captured while the first response waits.
    bready = 1'b0;
    bq.push_back(RESP_OKAY); sq.push_back(4); mdl[4] = 32'h5;
    awaddr = 32'h10; wdata = 32'h5;
    run_ch(0, 0, -1);
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("b_hold_valid", 32'(bvalid), 32'd1);
      chk("b_hold_resp",  32'(bresp), 32'(RESP_OKAY));
    end
    @(posedge clk); #1;
    bq.push_back(RESP_OKAY); sq.push_back(5); mdl[5] = 32'h6;
    awaddr = 32'h14; wdata = 32'h6;
    run_ch(0, 0, -1);
    @(negedge clk);
    chk("b_still_held", 32'(bvalid), 32'd1);
    chk("second_not_committed", 32'(sq.size()), 32'd1);
    @(posedge clk); #1;
    bready = 1'b1;
    wait_drain();
    chk("bp_strobe_missing", 32'(sq.size()), 32'd0);
    sq.delete();
    chk_regs("regs_backpressure");

    // Commit to reg 3 on the same edge as the AR handshake for reg 3.
    bq.push_back(RESP_OKAY); sq.push_back(3); rq.push_back({RESP_OKAY, 32'h0000_00AA});
    mdl[3] = 32'h55;
    awaddr = 32'hC; wdata = 32'h55; araddr = 32'hC;
    run_ch(0, 0, 1);
    chk("concurrent_same_edge", 32'({wr_strobe, rvalid}), 32'd3);
    wait_drain();
    do_read(32'hC, 32'h55, RESP_OKAY);
    chk_regs("regs_concurrent");

    // Reset while a write response is pending.
    bready = 1'b0;
    sq.push_back(6);
    awaddr = 32'h18; wdata = 32'h99;
    run_ch(0, 0, -1);
    @(negedge clk); @(negedge clk);
    chk("pre_reset_bvalid", 32'(bvalid), 32'd1);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    chk("async_bvalid",  32'(bvalid), 32'd0);
    chk("async_bresp",   32'(bresp), 32'd0);
    chk("async_rvalid",  32'(rvalid), 32'd0);
    chk("async_rdata",   rdata, 32'd0);
    chk("async_strobe",  32'(wr_strobe), 32'd0);
    chk("async_index",   32'(wr_index), 32'd0);
    chk_regs("async_regs");
    @(posedge clk); #2 reset = 1'b1;
    bready = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_b_after_reset", 32'(bvalid), 32'd0);
    sq.delete();
    @(posedge clk); #1;
    do_read(32'h4, 32'h0, RESP_OKAY);
    chk_regs("regs_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
